enum_coef_dbuf: RTL and testbench

//  Double-buffered reloadable FIR coefficient store, successor to the single-bank coef shift register.

---
 rtl/enum_coef_dbuf.sv | 111 +++++++++++
 tb/tb_enum_coef_dbuf.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/enum_coef_dbuf.sv
// Double-buffered FIR coefficient store: serial load into a shadow bank,
// single-cycle commit into the active bank read by the MAC array.
module enum_coef_dbuf #(
  parameter int TAPS       = 100,
  parameter int COEF_WIDTH = 12,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                       clk,
  input  logic                       nGrst,
  input  logic                       clkEn,
  input  logic                       rstn,
  input  logic [COEF_WIDTH-1:0]      coefi,
  input  logic                       coefi_valid,
  input  logic                       load_start,
  input  logic                       commit,
  input  logic                       clr_err,
  output logic [TAPS*COEF_WIDTH-1:0] flat_coefo,
  output logic [CNT_WIDTH-1:0]       load_cnt,
  output logic                       coef_ready,
  output logic                       commit_done,
  output logic                       err_ovf,
  output logic                       err_unf
);

  typedef enum logic [1:0] {IDLE, LOADING, FULL} state_t;

  localparam logic [CNT_WIDTH-1:0] TAPS_C = CNT_WIDTH'(TAPS);

  state_t                state, state_nxt;
  logic [CNT_WIDTH-1:0]  cnt_nxt;
  logic [CNT_WIDTH-1:0]  cnt_inc;
  logic                  shift_en;
  logic                  copy_en;
  logic                  done_nxt;
  logic                  ovf_set;
  logic                  unf_set;
  logic [COEF_WIDTH-1:0] shadow [TAPS];

  assign cnt_inc    = load_cnt + 1'b1;
  assign coef_ready = (state == FULL);

  // Priority: load_start > commit > coefi_valid; the winner consumes the cycle.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = load_cnt;
    shift_en  = 1'b0;
    copy_en   = 1'b0;
    done_nxt  = 1'b0;
    ovf_set   = 1'b0;
    unf_set   = 1'b0;
    if (load_start) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else if (commit) begin
      if (state == FULL) begin
        copy_en   = 1'b1;
        done_nxt  = 1'b1;
        cnt_nxt   = '0;
        state_nxt = IDLE;
        ovf_set   = coefi_valid;
      end else begin
        unf_set = 1'b1;
      end
    end else if (coefi_valid) begin
      if (state == FULL) begin
        ovf_set = 1'b1;
      end else begin
        shift_en  = 1'b1;
        cnt_nxt   = cnt_inc;
        state_nxt = (cnt_inc == TAPS_C) ? FULL : LOADING;
      end
    end
  end

  always_ff @(posedge clk or negedge nGrst) begin
    if (!nGrst) begin
      state       <= IDLE;
      load_cnt    <= '0;
      commit_done <= 1'b0;
      err_ovf     <= 1'b0;
      err_unf     <= 1'b0;
      flat_coefo  <= '0;
      for (int unsigned i = 0; i < TAPS; i++) shadow[i] <= '0;
    end else if (clkEn) begin
      if (!rstn) begin
        state       <= IDLE;
        load_cnt    <= '0;
        commit_done <= 1'b0;
        err_ovf     <= 1'b0;
        err_unf     <= 1'b0;
        flat_coefo  <= '0;
        for (int unsigned i = 0; i < TAPS; i++) shadow[i] <= '0;
      end else begin
        state       <= state_nxt;
        load_cnt    <= cnt_nxt;
        commit_done <= done_nxt;
        err_ovf     <= ovf_set | (err_ovf & ~clr_err);
        err_unf     <= unf_set | (err_unf & ~clr_err);
        if (shift_en) begin
          shadow[0] <= coefi;
          for (int unsigned i = 1; i < TAPS; i++) shadow[i] <= shadow[i-1];
        end
        if (copy_en) begin
          for (int unsigned i = 0; i < TAPS; i++)
            flat_coefo[COEF_WIDTH*i +: COEF_WIDTH] <= shadow[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_enum_coef_dbuf.sv
// Directed table-driven bench for enum_coef_dbuf (TAPS=4, COEF_WIDTH=8).
module tb_enum_coef_dbuf;

  localparam int TAPS = 4;
  localparam int CW   = 8;
  localparam int CNTW = 3;

  logic                 clk = 1'b0;
  logic                 nGrst, clkEn, rstn;
  logic [CW-1:0]        coefi;
  logic                 coefi_valid, load_start, commit, clr_err;
  logic [TAPS*CW-1:0]   flat_coefo;
  logic [CNTW-1:0]      load_cnt;
  logic                 coef_ready, commit_done, err_ovf, err_unf;

  int n_tests = 0;
  int n_fail  = 0;

  enum_coef_dbuf #(.TAPS(TAPS), .COEF_WIDTH(CW), .CNT_WIDTH(CNTW)) dut (
    .clk(clk), .nGrst(nGrst), .clkEn(clkEn), .rstn(rstn),
    .coefi(coefi), .coefi_valid(coefi_valid), .load_start(load_start),
    .commit(commit), .clr_err(clr_err), .flat_coefo(flat_coefo),
    .load_cnt(load_cnt), .coef_ready(coef_ready), .commit_done(commit_done),
    .err_ovf(err_ovf), .err_unf(err_unf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          en, rs, v, ls, cm, ce;
    logic [CW-1:0] d;
    logic [31:0]   f;
    logic [2:0]    c;
    logic          rdy, dn, ov, un;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic en, logic rs, logic [7:0] d, logic v, logic ls,
                              logic cm, logic ce, logic [31:0] f, logic [2:0] c,
                              logic rdy, logic dn, logic ov, logic un);
    vec_t r;
    r.en = en; r.rs = rs; r.d = d; r.v = v; r.ls = ls; r.cm = cm; r.ce = ce;
    r.f = f; r.c = c; r.rdy = rdy; r.dn = dn; r.ov = ov; r.un = un;
    return r;
  endfunction

  task automatic check(string nm, logic [31:0] f, logic [2:0] c,
                       logic rdy, logic dn, logic ov, logic un);
    n_tests++;
    if (flat_coefo !== f || load_cnt !== c || coef_ready !== rdy ||
        commit_done !== dn || err_ovf !== ov || err_unf !== un) begin
      n_fail++;
      $display("FAIL %s: got flat=%h cnt=%0d rdy=%b done=%b ovf=%b unf=%b; want flat=%h cnt=%0d rdy=%b done=%b ovf=%b unf=%b",
               nm, flat_coefo, load_cnt, coef_ready, commit_done, err_ovf, err_unf,
               f, c, rdy, dn, ov, un);
    end
  endtask

  task automatic apply(vec_t t, string nm);
    @(negedge clk);
    clkEn = t.en; rstn = t.rs; coefi = t.d; coefi_valid = t.v;
    load_start = t.ls; commit = t.cm; clr_err = t.ce;
    @(posedge clk);
    #1;
    check(nm, t.f, t.c, t.rdy, t.dn, t.ov, t.un);
  endtask

  task automatic ld(logic [7:0] d, logic [31:0] f, logic [2:0] c, logic rdy, string nm);
    apply(mk(1,1,d,1,0,0,0, f,c,rdy,0,0,0), nm);
  endtask

  localparam logic [31:0] F1 = 32'h0B16212C;
  localparam logic [31:0] F2 = 32'h01020304;
  localparam logic [31:0] F3 = 32'hA1A2A3A4;
  localparam logic [31:0] F4 = 32'h10203040;
  localparam logic [31:0] F5 = 32'hC1C2C3C4;

  initial begin
    nGrst = 1'b0; clkEn = 1'b1; rstn = 1'b1; coefi = '0;
    coefi_valid = 1'b0; load_start = 1'b0; commit = 1'b0; clr_err = 1'b0;

    //             en rs d     v ls cm ce  flat c rdy dn ov un
    tbl.push_back(mk(1,1,8'h00,0,0,1,0, 0,0,0,0,0,1));   // commit in IDLE
    tbl.push_back(mk(1,1,8'h00,0,0,0,1, 0,0,0,0,0,0));
    tbl.push_back(mk(1,1,8'd11,1,0,0,0, 0,1,0,0,0,0));
    tbl.push_back(mk(1,1,8'd22,1,0,0,0, 0,2,0,0,0,0));
    tbl.push_back(mk(1,1,8'd33,1,0,0,0, 0,3,0,0,0,0));
    tbl.push_back(mk(1,1,8'd44,1,0,0,0, 0,4,1,0,0,0));
    tbl.push_back(mk(1,1,8'h00,0,0,1,0, F1,0,0,1,0,0));
    tbl.push_back(mk(1,1,8'h00,0,0,0,0, F1,0,0,0,0,0));
    tbl.push_back(mk(1,1,8'h01,1,0,0,0, F1,1,0,0,0,0));
    tbl.push_back(mk(1,1,8'h02,1,0,0,0, F1,2,0,0,0,0));
    tbl.push_back(mk(1,1,8'h03,1,0,0,0, F1,3,0,0,0,0));
    tbl.push_back(mk(1,1,8'h00,0,0,1,0, F1,3,0,0,0,1));  // underflow
    tbl.push_back(mk(1,1,8'h04,1,0,0,0, F1,4,1,0,0,1));
    tbl.push_back(mk(1,1,8'h05,1,0,0,0, F1,4,1,0,1,1));  // overflow
    tbl.push_back(mk(1,1,8'h00,0,0,1,0, F2,0,0,1,1,1));
    tbl.push_back(mk(1,1,8'h00,0,0,0,1, F2,0,0,0,0,0));
    tbl.push_back(mk(1,1,8'hAA,1,0,0,0, F2,1,0,0,0,0));
    tbl.push_back(mk(1,1,8'hBB,1,0,0,0, F2,2,0,0,0,0));
    tbl.push_back(mk(1,1,8'hCC,1,1,1,0, F2,0,0,0,0,0));  // load_start wins
    tbl.push_back(mk(1,1,8'hA1,1,0,0,0, F2,1,0,0,0,0));
    tbl.push_back(mk(1,1,8'hA2,1,0,0,0, F2,2,0,0,0,0));
    tbl.push_back(mk(1,1,8'hA3,1,0,0,0, F2,3,0,0,0,0));
    tbl.push_back(mk(1,1,8'hA4,1,0,0,0, F2,4,1,0,0,0));
    tbl.push_back(mk(1,1,8'h55,1,0,0,1, F2,4,1,0,1,0));  // set beats clear
    tbl.push_back(mk(1,1,8'h00,0,0,0,1, F2,4,1,0,0,0));
    tbl.push_back(mk(1,1,8'h66,1,0,1,0, F3,0,0,1,1,0));  // commit + dropped coef
    tbl.push_back(mk(0,1,8'h77,1,0,1,0, F3,0,0,1,1,0));  // clkEn=0 holds all
    tbl.push_back(mk(0,1,8'h00,0,0,0,1, F3,0,0,1,1,0));
    tbl.push_back(mk(1,1,8'h00,0,0,0,1, F3,0,0,0,0,0));
    tbl.push_back(mk(1,1,8'h11,1,0,0,0, F3,1,0,0,0,0));
    tbl.push_back(mk(0,1,8'h00,0,0,1,0, F3,1,0,0,0,0));
    tbl.push_back(mk(0,0,8'h00,0,0,0,0, F3,1,0,0,0,0));  // rstn gated by clkEn
    tbl.push_back(mk(1,0,8'h12,1,0,0,0, 0,0,0,0,0,0));   // sync clear
    tbl.push_back(mk(1,1,8'h00,0,0,0,0, 0,0,0,0,0,0));

    #12;
    check("reset", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    nGrst = 1'b1;

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Async reset mid-load after a committed bank.
    ld(8'h10, 0, 1, 0, "a_l1");
    ld(8'h20, 0, 2, 0, "a_l2");
    ld(8'h30, 0, 3, 0, "a_l3");
    ld(8'h40, 0, 4, 1, "a_l4");
    apply(mk(1,1,8'h00,0,0,1,0, F4,0,0,1,0,0), "a_commit");
    ld(8'h99, F4, 1, 0, "a_m1");
    ld(8'h98, F4, 2, 0, "a_m2");
    @(negedge clk);
    coefi_valid = 1'b0;
    #2;
    nGrst = 1'b0;
    #1;
    check("async_rst", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    nGrst = 1'b1;
    ld(8'hC1, 0, 1, 0, "r_l1");
    ld(8'hC2, 0, 2, 0, "r_l2");
    ld(8'hC3, 0, 3, 0, "r_l3");
    ld(8'hC4, 0, 4, 1, "r_l4");
    apply(mk(1,1,8'h00,0,0,1,0, F5,0,0,1,0,0), "r_commit");
    apply(mk(1,1,8'h00,0,0,0,0, F5,0,0,0,0,0), "r_idle");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
